// File: rtl/serial_addsub_if.sv
// Bus bundle for serial_addsub: request side (start/sub/a/b) and
// result side (busy/done/s/co/ovf).
//
// Handshake: the master raises start with sub/a/b stable; the request is
// taken on the rising edge where start=1 and busy=0. busy is high while
// the operation runs, and starts ignored while busy is high. done pulses
// for exactly one cycle when s/co/ovf carry a new result. Those outputs
// then hold until the next done.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered carry
// process the operands LSB first, one bit per clock. A subtract is done as
// a + ~b + 1, with the +1 entering as the initial carry.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_if.slave        bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Holds the WIDTH-1 sum bits produced so far. The newest bit sits at the top.
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ovf_q;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;

  // Full-adder cell on the current LSBs, plus the result after this bit.
  always_comb begin
    sum_bit   = op_a[0] ^ op_b[0] ^ carry;
    carry_out = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    res_next  = {sum_bit, res};
  end

  // Control FSM with datapath shifting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts a start directly, so back-to-back ops skip IDLE.
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res   <= res_next[WIDTH-1:1];
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          carry <= carry_out;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // The MSB is being processed. carry is the carry into the MSB.
            s_q    <= res_next;
            co_q   <= carry_out;
            ovf_q  <= carry ^ carry_out;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.co    = co_q;
  assign bus.ovf   = ovf_q;
  assign state_dbg = state;

endmodule
